target_digit_gen: RTL and testbench

TARGET_DIGIT_GEN -- requirements
Module: target_digit_gen

---
 rtl/target_digit_gen.sv | 146 ++++++++++++++
 tb/tb_target_digit_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/target_digit_gen.sv
// Random BCD target generator: a Galois LFSR feeds rejection-sampled digits, forced after FORCE_LIMIT rejects.
// Define TARGET_GEN_NODUP_EN to forbid repeated digits within one target.
module target_digit_gen #(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned FORCE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_round,
  input  logic [1:0]  max_digits,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic [3:0]  target_digit_1,
  output logic [3:0]  target_digit_2,
  output logic [3:0]  target_digit_3,
  output logic        target_valid,
  output logic        busy
);

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] RESET_SEED   = (LFSR_SEED == 16'h0) ? DEFAULT_SEED : LFSR_SEED;
  localparam logic [15:0] TAPS         = 16'hB400;
  localparam int unsigned RW           = (FORCE_LIMIT > 1) ? $clog2(FORCE_LIMIT) : 1;
  localparam logic [RW-1:0] REJ_MAX    = RW'(FORCE_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_e;

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [1:0]        n_q, n_d;
  logic [1:0]        idx_q, idx_d;
  logic [RW-1:0]     rej_q, rej_d;
  logic [2:0][3:0]   dig_q, dig_d;
  logic              target_valid_q, target_valid_d;
  logic              busy_q, busy_d;

  logic [15:0]       lfsr_step;
  logic [15:0]       seed_fix;
  logic [3:0]        cand;
  logic [3:0]        fill;
  logic [3:0]        pick;
  logic              last;
  logic              dup;
  logic              legal;
`ifdef TARGET_GEN_NODUP_EN
  logic              found;
  logic              taken;
`endif

  // Candidate qualification and forced-accept fill value
  always_comb begin
    lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    seed_fix  = (seed == 16'h0) ? DEFAULT_SEED : seed;
    cand      = lfsr_q[3:0];
    last      = (idx_q == (n_q - 2'd1)) && (n_q > 2'd1);
`ifdef TARGET_GEN_NODUP_EN
    dup = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if ((2'(i) < idx_q) && (dig_q[i] == cand)) dup = 1'b1;
    end
    fill  = 4'd0;
    found = 1'b0;
    for (int v = 0; v < 10; v++) begin
      taken = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if ((2'(i) < idx_q) && (dig_q[i] == 4'(v))) taken = 1'b1;
      end
      if (!found && !taken && !(last && (v == 0))) begin
        fill  = 4'(v);
        found = 1'b1;
      end
    end
`else
    dup  = 1'b0;
    fill = last ? 4'd1 : 4'd0;
`endif
    legal = (cand <= 4'd9) && !(last && (cand == 4'd0)) && !dup;
    pick  = legal ? cand : fill;
  end

  // Next-state logic; new_round takes priority in every state
  always_comb begin
    state_d        = state_q;
    lfsr_d         = seed_load ? seed_fix : lfsr_step;
    n_d            = n_q;
    idx_d          = idx_q;
    rej_d          = rej_q;
    dig_d          = dig_q;
    target_valid_d = target_valid_q;
    busy_d         = busy_q;

    if (new_round) begin
      n_d            = (max_digits == 2'd0) ? 2'd1 : max_digits;
      idx_d          = 2'd0;
      rej_d          = '0;
      dig_d          = '0;
      target_valid_d = 1'b0;
      busy_d         = 1'b1;
      state_d        = DRAW;
    end else if (state_q == DRAW) begin
      if (legal || (rej_q == REJ_MAX)) begin
        for (int i = 0; i < 3; i++) begin
          if (2'(i) == idx_q) dig_d[i] = pick;
        end
        idx_d = idx_q + 2'd1;
        rej_d = '0;
        if ((idx_q + 2'd1) == n_q) begin
          state_d        = DONE;
          target_valid_d = 1'b1;
          busy_d         = 1'b0;
        end
      end else begin
        rej_d = rej_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      lfsr_q         <= RESET_SEED;
      n_q            <= 2'd1;
      idx_q          <= 2'd0;
      rej_q          <= '0;
      dig_q          <= '0;
      target_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      n_q            <= n_d;
      idx_q          <= idx_d;
      rej_q          <= rej_d;
      dig_q          <= dig_d;
      target_valid_q <= target_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign target_digit_1 = dig_q[0];
  assign target_digit_2 = dig_q[1];
  assign target_digit_3 = dig_q[2];
  assign target_valid   = target_valid_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_target_digit_gen.sv
// Scoreboard bench for target_digit_gen: stimulus pushes predicted targets, a monitor pops on target_valid.
module tb_target_digit_gen;

`ifdef TARGET_GEN_NODUP_EN
  localparam int FL = 2;
  localparam bit NODUP = 1'b1;
`else
  localparam int FL = 16;
  localparam bit NODUP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        new_round = 1'b0;
  logic [1:0]  max_digits = 2'd0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'h0;
  logic [3:0]  target_digit_1, target_digit_2, target_digit_3;
  logic        target_valid, busy;

  target_digit_gen #(.LFSR_SEED(16'hACE1), .FORCE_LIMIT(FL)) dut (
    .clk(clk), .rst(rst), .new_round(new_round), .max_digits(max_digits),
    .seed_load(seed_load), .seed(seed),
    .target_digit_1(target_digit_1), .target_digit_2(target_digit_2),
    .target_digit_3(target_digit_3), .target_valid(target_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d1, d2, d3;
    int lat;
    int n;
    int issue;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          dup_seen = 0;
  logic [15:0] m_lfsr;
  bit          prev_v = 1'b0;

  function automatic logic [15:0] step(logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic logic [15:0] fix(logic [15:0] s);
    return (s == 16'h0) ? 16'hACE1 : s;
  endfunction

  // Draw-by-draw reference: walks the candidate stream until n digits are accepted
  function automatic exp_t model(logic [15:0] start, int md, int reload_at, logic [15:0] rv, int issue);
    exp_t r;
    int d[3];
    int n, idx, rej, dcyc, c;
    bit ok, found;
    logic [15:0] l;
    n = (md == 0) ? 1 : md;
    d = '{0, 0, 0};
    l = start; idx = 0; rej = 0; dcyc = 0;
    while (idx < n && dcyc < 1000) begin
      dcyc++;
      if (dcyc == reload_at) l = rv;
      c = int'(l[3:0]);
      ok = (c <= 9) && !(idx == n - 1 && n > 1 && c == 0);
      if (NODUP) for (int i = 0; i < idx; i++) if (d[i] == c) ok = 1'b0;
      if (ok) begin
        d[idx] = c; idx++; rej = 0;
      end else if (rej == FL - 1) begin
        found = 1'b0;
        for (int v = 0; v < 10; v++) begin
          ok = !(idx == n - 1 && n > 1 && v == 0);
          if (NODUP) for (int i = 0; i < idx; i++) if (d[i] == v) ok = 1'b0;
          if (ok && !found) begin d[idx] = v; found = 1'b1; end
        end
        idx++; rej = 0;
      end else begin
        rej++;
      end
      l = step(l);
    end
    r.d1 = d[0]; r.d2 = d[1]; r.d3 = d[2];
    r.lat = dcyc + 1; r.n = n; r.issue = issue;
    return r;
  endfunction

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Spec-level LFSR tracker, read by stimulus to predict the first candidate
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else if (seed_load) m_lfsr <= fix(seed);
    else m_lfsr <= step(m_lfsr);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares each completed target against the oldest prediction
  always @(negedge clk) begin
    if (rst && target_valid && !prev_v) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: got target_valid=1 expected no pending round");
      end else begin
        e = sb.pop_front();
        check("digit_1", int'(target_digit_1), e.d1);
        check("digit_2", int'(target_digit_2), e.d2);
        check("digit_3", int'(target_digit_3), e.d3);
        check("latency", cyc - e.issue, e.lat);
        check("busy_done", int'(busy), 0);
        check("lat_bound", int'((cyc - e.issue) <= e.n * FL + 1), 1);
        if (e.n == 3) begin
          check("digit_3_nonzero", int'(target_digit_3 != 4'd0), 1);
          if (target_digit_1 == target_digit_2 || target_digit_1 == target_digit_3 ||
              target_digit_2 == target_digit_3) dup_seen++;
        end
      end
    end
    prev_v = target_valid;
  end

  task automatic issue(int md, bit sl, logic [15:0] sd, bit mid, logic [15:0] mv, bit push);
    logic [15:0] start;
    @(negedge clk);
    start      = sl ? fix(sd) : step(m_lfsr);
    max_digits = 2'(md);
    new_round  = 1'b1;
    seed_load  = sl;
    seed       = sd;
    if (push) sb.push_back(model(start, md, mid ? 2 : 0, fix(mv), cyc));
    @(negedge clk);
    new_round = 1'b0;
    seed_load = mid;
    seed      = mv;
    check("busy_after_req", int'(busy), 1);
    if (mid) begin
      @(negedge clk);
      seed_load = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 400 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      check("round_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", int'(target_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_digits", int'({target_digit_3, target_digit_2, target_digit_1}), 0);
    rst = 1'b1;

    // Seed then single-digit round
    @(negedge clk);
    seed_load = 1'b1; seed = 16'h0001;
    @(negedge clk);
    seed_load = 1'b0;
    issue(1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    wait_done();

    // Zero seed replaced by default; max_digits 0 acts as 1
    issue(2, 1'b1, 16'h0000, 1'b0, 16'h0, 1'b1);
    wait_done();
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b1, 16'(i * 16'h1357 + 16'h0021), 1'b0, 16'h0, 1'b1);
      wait_done();
    end

    // Reseed mid-draw without aborting
    issue(3, 1'b0, 16'h0, 1'b1, 16'h1234, 1'b1);
    wait_done();
    issue(3, 1'b0, 16'h0, 1'b1, 16'h0000, 1'b1);
    wait_done();

    // Restart two cycles into DRAW
    issue(3, 1'b1, 16'hBEEF, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    check("restart_valid_low", int'(target_valid), 0);
    issue(3, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    wait_done();

    // Asynchronous reset mid-draw
    issue(3, 1'b1, 16'h00F0, 1'b0, 16'h0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("midrst_valid", int'(target_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_digits", int'({target_digit_3, target_digit_2, target_digit_1}), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", int'(busy), 0);
    issue(3, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    wait_done();

    // Random mix of digit counts and seeds
    for (int i = 0; i < 300; i++) begin
      logic [15:0] s;
      s = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      issue(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), s, 1'b0, 16'h0, 1'b1);
      wait_done();
    end

    // Long three-digit run with random seeds
    for (int i = 0; i < 1000; i++) begin
      issue(3, 1'b1, 16'($urandom), 1'b0, 16'h0, 1'b1);
      wait_done();
    end

    if (NODUP) check("no_duplicates", dup_seen, 0);
    else check("duplicates_seen", int'(dup_seen > 0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

endmodule
